control_unit: RTL

Control state machine for the 9-bit register-transfer processor. It sits directly upstream of the datapath. It sequences each instruction through time steps T0–T3 and drives every register-enable, bus-select and ALU control line the datapath consumes. The instruction word is the datapath's IR output, fed back in. Instruction format is IIIXXXYYY: opcode IR[8:6], Rx IR[5:3], Ry IR[2:0].

---
 rtl/control_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Step sequencer for the 9-bit register-transfer processor.
//               Walks each instruction through T0..T3 and decodes the
//               current step plus the IR word into every register-enable,
//               bus-select and ALU control line of the datapath.
//               Instruction word: IIIXXXYYY (opcode, Rx, Ry).
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [8:0] IRdata,
    output logic       R0i,
    output logic       R1i,
    output logic       R2i,
    output logic       R3i,
    output logic       R4i,
    output logic       R5i,
    output logic       R6i,
    output logic       R7i,
    output logic       R0o,
    output logic       R1o,
    output logic       R2o,
    output logic       R3o,
    output logic       R4o,
    output logic       R5o,
    output logic       R6o,
    output logic       R7o,
    output logic       A_in,
    output logic       addsub,
    output logic       G_in,
    output logic       G_out,
    output logic       DIN_out,
    output logic       IR_in,
    output logic       done,
    output logic [1:0] tstep
);

    // Opcode field values
    localparam logic [2:0] c_OP_MV  = 3'b000;
    localparam logic [2:0] c_OP_MVI = 3'b001;
    localparam logic [2:0] c_OP_ADD = 3'b010;
    localparam logic [2:0] c_OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next_state;

    // Instruction fields, decoded every cycle from the datapath IR
    logic [2:0] w_opcode;
    logic [2:0] w_rx;
    logic [2:0] w_ry;
    logic [7:0] w_rx_sel;
    logic [7:0] w_ry_sel;

    // Raw (pre-reset-gating) control decode
    logic [7:0] w_rin;
    logic [7:0] w_rout;
    logic       w_a_in;
    logic       w_addsub;
    logic       w_g_in;
    logic       w_g_out;
    logic       w_din_out;
    logic       w_ir_in;
    logic       w_done;

    // Reset-gated versions of the register select vectors
    logic [7:0] w_rin_g;
    logic [7:0] w_rout_g;

    assign w_opcode = IRdata[8:6];
    assign w_rx     = IRdata[5:3];
    assign w_ry     = IRdata[2:0];
    assign w_rx_sel = 8'b0000_0001 << w_rx;
    assign w_ry_sel = 8'b0000_0001 << w_ry;

    // Step register: reset always returns to T0, otherwise follow the decode
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= T0;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-step and control decode; every line idles low unless a step drives it
    always_comb begin
        w_next_state = r_state;
        w_rin        = 8'b0;
        w_rout       = 8'b0;
        w_a_in       = 1'b0;
        w_addsub     = 1'b0;
        w_g_in       = 1'b0;
        w_g_out      = 1'b0;
        w_din_out    = 1'b0;
        w_ir_in      = 1'b0;
        w_done       = 1'b0;

        case (r_state)
            T0: begin
                // Fetch: IR captures din on the edge that leaves T0
                w_ir_in      = run;
                w_next_state = run ? T1 : T0;
            end
            T1: begin
                w_next_state = T0;
                case (w_opcode)
                    c_OP_MV: begin
                        w_rout = w_ry_sel;
                        w_rin  = w_rx_sel;
                        w_done = 1'b1;
                    end
                    c_OP_MVI: begin
                        w_din_out = 1'b1;
                        w_rin     = w_rx_sel;
                        w_done    = 1'b1;
                    end
                    c_OP_ADD, c_OP_SUB: begin
                        // First operand goes into A
                        w_rout       = w_rx_sel;
                        w_a_in       = 1'b1;
                        w_next_state = T2;
                    end
                    default: begin
                        // Opcodes 100..111 retire as NOPs
                        w_done = 1'b1;
                    end
                endcase
            end
            T2: begin
                // Second operand on the bus, ALU result into G.
                // Only add/sub reach T2, and IR[6] separates them.
                w_rout       = w_ry_sel;
                w_g_in       = 1'b1;
                w_addsub     = IRdata[6];
                w_next_state = T3;
            end
            T3: begin
                // Write the ALU result back to Rx
                w_g_out      = 1'b1;
                w_rin        = w_rx_sel;
                w_done       = 1'b1;
                w_next_state = T0;
            end
            default: begin
                w_next_state = T0;
            end
        endcase
    end

    // While reset is asserted nothing may be enabled, including the fetch
    assign w_rin_g  = reset ? 8'b0 : w_rin;
    assign w_rout_g = reset ? 8'b0 : w_rout;

    assign {R7i, R6i, R5i, R4i, R3i, R2i, R1i, R0i} = w_rin_g;
    assign {R7o, R6o, R5o, R4o, R3o, R2o, R1o, R0o} = w_rout_g;

    assign A_in    = w_a_in    & ~reset;
    assign addsub  = w_addsub  & ~reset;
    assign G_in    = w_g_in    & ~reset;
    assign G_out   = w_g_out   & ~reset;
    assign DIN_out = w_din_out & ~reset;
    assign IR_in   = w_ir_in   & ~reset;
    assign done    = w_done    & ~reset;
    assign tstep   = reset ? 2'd0 : r_state;

endmodule
`default_nettype wire
